// File: rtl/vga_sync_generator.sv
// ---------------------------------------------------------------------------
// vga_sync_generator
//   Raster timing source for the VGA display path. Divides the board clock down
//   to the pixel rate and scans an H_TOTAL x V_TOTAL frame (640x480@60 default).
//
//   Optional feature macro: VGA_RGB_BLANK_EN
//     defined   -> adds 1-bit colour inputs i_r_in/i_g_in/i_b_in and blanked
//                  colour outputs o_vga_r/o_vga_g/o_vga_b. Colour and sync reach
//                  the connector one pixel after the position outputs, so they
//                  stay aligned with each other.
//     undefined -> no colour ports, no delay stage.
//
// Ports
//   i_clk             board clock
//   i_reset_n         asynchronous active-low reset
//   o_pixel_tick      1-clk pulse every CLK_DIV clks; the outputs below change
//                     only on the edge that raises it
//   o_column, o_row   position of the pixel being presented
//   o_display_enable  pixel is inside the visible area
//   o_hsync, o_vsync  sync outputs, SYNC_ACTIVE while asserted
//   o_frame_start     1-clk pulse with the tick that presents (0,0)
//
// Porch and sync widths must each be >= 1; all sums must fit in 16 bits.
// ---------------------------------------------------------------------------
module vga_sync_generator #(
    parameter int   CLK_DIV     = 2,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
`ifdef VGA_RGB_BLANK_EN
    input  logic        i_r_in,
    input  logic        i_g_in,
    input  logic        i_b_in,
    output logic        o_vga_r,
    output logic        o_vga_g,
    output logic        o_vga_b,
`endif
    output logic        o_pixel_tick,
    output logic [15:0] o_column,
    output logic [15:0] o_row,
    output logic        o_display_enable,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_start
);

    // Last position of each phase; an FSM leaves a phase when the counter it
    // shadows steps past that phase's last position.
    localparam logic [15:0] H_ACT_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] H_FP_LAST   = 16'(H_ACTIVE + H_FP - 1);
    localparam logic [15:0] H_SYNC_LAST = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] H_LAST      = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_ACT_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] V_FP_LAST   = 16'(V_ACTIVE + V_FP - 1);
    localparam logic [15:0] V_SYNC_LAST = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [15:0] V_LAST      = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_FRONT,
        ST_SYNC,
        ST_BACK
    } phase_t;

    logic [DIV_W-1:0] r_div;
    // r_h/r_v and the FSM states describe the NEXT pixel to present, so the
    // first tick after reset presents (0,0) without any special case.
    logic [15:0]      r_h;
    logic [15:0]      r_v;
    phase_t           r_hst;
    phase_t           r_vst;
    logic             r_hs;
    logic             r_vs;
    logic             w_tick;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div            <= '0;
            r_h              <= '0;
            r_v              <= '0;
            r_hst            <= ST_ACTIVE;
            r_vst            <= ST_ACTIVE;
            r_hs             <= ~SYNC_ACTIVE;
            r_vs             <= ~SYNC_ACTIVE;
            o_pixel_tick     <= 1'b0;
            o_column         <= '0;
            o_row            <= '0;
            o_display_enable <= 1'b0;
            o_frame_start    <= 1'b0;
`ifdef VGA_RGB_BLANK_EN
            o_vga_r          <= 1'b0;
            o_vga_g          <= 1'b0;
            o_vga_b          <= 1'b0;
            o_hsync          <= ~SYNC_ACTIVE;
            o_vsync          <= ~SYNC_ACTIVE;
`endif
        end else begin
            o_pixel_tick  <= w_tick;
            o_frame_start <= 1'b0;
            r_div         <= w_tick ? '0 : r_div + DIV_W'(1);

            if (w_tick) begin
`ifdef VGA_RGB_BLANK_EN
                // Colour of the pixel currently on the outputs, blanked by
                // its own enable, goes out together with its own sync levels.
                o_vga_r <= i_r_in & o_display_enable;
                o_vga_g <= i_g_in & o_display_enable;
                o_vga_b <= i_b_in & o_display_enable;
                o_hsync <= r_hs;
                o_vsync <= r_vs;
`endif
                o_column         <= r_h;
                o_row            <= r_v;
                o_display_enable <= (r_hst == ST_ACTIVE) && (r_vst == ST_ACTIVE);
                r_hs             <= (r_hst == ST_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_vs             <= (r_vst == ST_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                o_frame_start    <= (r_h == '0) && (r_v == '0);

                if (r_h == H_LAST) begin
                    r_h   <= '0;
                    r_hst <= ST_ACTIVE;
                    if (r_v == V_LAST) begin
                        r_v   <= '0;
                        r_vst <= ST_ACTIVE;
                    end else begin
                        r_v <= r_v + 16'd1;
                        case (r_vst)
                            ST_ACTIVE: if (r_v == V_ACT_LAST)  r_vst <= ST_FRONT;
                            ST_FRONT:  if (r_v == V_FP_LAST)   r_vst <= ST_SYNC;
                            ST_SYNC:   if (r_v == V_SYNC_LAST) r_vst <= ST_BACK;
                            default:   ;
                        endcase
                    end
                end else begin
                    r_h <= r_h + 16'd1;
                    case (r_hst)
                        ST_ACTIVE: if (r_h == H_ACT_LAST)  r_hst <= ST_FRONT;
                        ST_FRONT:  if (r_h == H_FP_LAST)   r_hst <= ST_SYNC;
                        ST_SYNC:   if (r_h == H_SYNC_LAST) r_hst <= ST_BACK;
                        default:   ;
                    endcase
                end
            end
        end
    end

`ifndef VGA_RGB_BLANK_EN
    assign o_hsync = r_hs;
    assign o_vsync = r_vs;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a full-size instance (640x480, CLK_DIV=2) for
// line timing and a tiny-raster instance (15x8, CLK_DIV=1) for frame timing.
// The reference model derives every output from the number of clock edges
// since reset release using plain division/modulo on the raster geometry.
module tb_vga_sync_generator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_in = 1'b1, g_in = 1'b0, b_in = 1'b1;

    always #5 clk = ~clk;

    logic        d_tick, d_de, d_hs, d_vs, d_fs;
    logic [15:0] d_col, d_row;
    logic        s_tick, s_de, s_hs, s_vs, s_fs;
    logic [15:0] s_col, s_row;
    logic        d_vr, d_vg, d_vb, s_vr, s_vg, s_vb;

    vga_sync_generator dut (
        .i_clk(clk), .i_reset_n(rst_n),
`ifdef VGA_RGB_BLANK_EN
        .i_r_in(r_in), .i_g_in(g_in), .i_b_in(b_in),
        .o_vga_r(d_vr), .o_vga_g(d_vg), .o_vga_b(d_vb),
`endif
        .o_pixel_tick(d_tick), .o_column(d_col), .o_row(d_row),
        .o_display_enable(d_de), .o_hsync(d_hs), .o_vsync(d_vs),
        .o_frame_start(d_fs)
    );

    vga_sync_generator #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
    ) dut_s (
        .i_clk(clk), .i_reset_n(rst_n),
`ifdef VGA_RGB_BLANK_EN
        .i_r_in(r_in), .i_g_in(g_in), .i_b_in(b_in),
        .o_vga_r(s_vr), .o_vga_g(s_vg), .o_vga_b(s_vb),
`endif
        .o_pixel_tick(s_tick), .o_column(s_col), .o_row(s_row),
        .o_display_enable(s_de), .o_hsync(s_hs), .o_vsync(s_vs),
        .o_frame_start(s_fs)
    );

`ifndef VGA_RGB_BLANK_EN
    assign {d_vr, d_vg, d_vb, s_vr, s_vg, s_vb} = '0;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct packed {
        logic        tick;
        logic [15:0] col;
        logic [15:0] row;
        logic        de, hs, vs, fs, vr, vg, vb;
    } exp_t;

    // Expected outputs after n clock edges since reset release.
    function automatic exp_t model(input int n, input int div,
                                   input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp);
        exp_t e;
        int ht, vt, k, p, h, v, hp, vp;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        k = n / div;                       // ticks so far
        if (k == 0) return e;
        p = k - 1;                         // pixel index being presented
        h = p % ht;
        v = (p / ht) % vt;
        e.tick = (n % div == 0);
        e.col  = 16'(h);
        e.row  = 16'(v);
        e.de   = (h < ha) && (v < va);
        e.fs   = e.tick && (h == 0) && (v == 0);
`ifdef VGA_RGB_BLANK_EN
        if (p >= 1) begin
            hp = (p - 1) % ht;
            vp = ((p - 1) / ht) % vt;
            e.hs = !(hp >= ha + hfp && hp < ha + hfp + hsw);
            e.vs = !(vp >= va + vfp && vp < va + vfp + vsw);
            e.vr = r_in && (hp < ha) && (vp < va);
            e.vg = g_in && (hp < ha) && (vp < va);
            e.vb = b_in && (hp < ha) && (vp < va);
        end
`else
        hp = 0; vp = 0;
        e.hs = !(h >= ha + hfp && h < ha + hfp + hsw);
        e.vs = !(v >= va + vfp && v < va + vfp + vsw);
`endif
        return e;
    endfunction

    // Edges since reset release.
    int n_e;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) n_e <= 0;
        else        n_e <= n_e + 1;

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t e, f;
        e = model(n_e, 2, 640, 16, 96, 48, 480, 10, 2, 33);
        f = model(n_e, 1, 8, 2, 3, 2, 4, 1, 2, 1);
        cmp("d.tick", int'(d_tick), int'(e.tick));
        cmp("d.col",  int'(d_col),  int'(e.col));
        cmp("d.row",  int'(d_row),  int'(e.row));
        cmp("d.de",   int'(d_de),   int'(e.de));
        cmp("d.hs",   int'(d_hs),   int'(e.hs));
        cmp("d.vs",   int'(d_vs),   int'(e.vs));
        cmp("d.fs",   int'(d_fs),   int'(e.fs));
        cmp("d.rgb",  int'({d_vr, d_vg, d_vb}), int'({e.vr, e.vg, e.vb}));
        cmp("s.tick", int'(s_tick), int'(f.tick));
        cmp("s.col",  int'(s_col),  int'(f.col));
        cmp("s.row",  int'(s_row),  int'(f.row));
        cmp("s.de",   int'(s_de),   int'(f.de));
        cmp("s.hs",   int'(s_hs),   int'(f.hs));
        cmp("s.vs",   int'(s_vs),   int'(f.vs));
        cmp("s.fs",   int'(s_fs),   int'(f.fs));
        cmp("s.rgb",  int'({s_vr, s_vg, s_vb}), int'({f.vr, f.vg, f.vb}));
    end

    task automatic check_reset_vals(input string tag);
        cmp({tag, ".d_out"}, int'({d_tick, d_col, d_row, d_de, d_hs, d_vs, d_fs}),
            int'({1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0}));
        cmp({tag, ".s_out"}, int'({s_tick, s_col, s_row, s_de, s_hs, s_vs, s_fs}),
            int'({1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0}));
        cmp({tag, ".rgb"}, int'({d_vr, d_vg, d_vb, s_vr, s_vg, s_vb}), 0);
    endtask

    // Release reset and check the first two ticks of the full-size instance.
    task automatic release_and_check_start(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cmp({tag, ".edge1_tick"}, int'(d_tick), 0);
        cmp({tag, ".s_edge1"}, int'({s_tick, s_col, s_row, s_de, s_fs}),
            int'({1'b1, 16'd0, 16'd0, 1'b1, 1'b1}));
        @(posedge clk); #1;
        cmp({tag, ".first_tick"}, int'({d_tick, d_col, d_row, d_de, d_fs}),
            int'({1'b1, 16'd0, 16'd0, 1'b1, 1'b1}));
        @(posedge clk); #1;
        cmp({tag, ".hold_col"}, int'({d_tick, d_col}), int'({1'b0, 16'd0}));
        @(posedge clk); #1;
        cmp({tag, ".second_tick"}, int'({d_tick, d_col, d_fs}), int'({1'b1, 16'd1, 1'b0}));
    endtask

    initial begin
        int lo_cnt, lo_min, lo_max, de_off, period, t0;
        int fs_cnt, fs_gap, fs_last, vs_cnt, de_bad;
        bit found;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        release_and_check_start("start");

        // One full-size line.
        lo_cnt = 0; lo_min = 99999; lo_max = -1; de_off = -1; period = -1; t0 = 2;
        for (int i = 0; i < 4000 && period < 0; i++) begin
            @(posedge clk); #1;
            if (d_tick) begin
                if (d_row == 16'd0) begin
                    if (!d_hs) begin
                        lo_cnt++;
                        if (int'(d_col) < lo_min) lo_min = int'(d_col);
                        if (int'(d_col) > lo_max) lo_max = int'(d_col);
                    end
                    if (!d_de && de_off < 0) de_off = int'(d_col);
                end else if (d_row == 16'd1 && d_col == 16'd0) begin
                    period = n_e - t0;
                end
            end
        end
        cmp("line.de_off_col", de_off, 640);
        cmp("line.hsync_ticks", lo_cnt, 96);
`ifdef VGA_RGB_BLANK_EN
        cmp("line.hsync_first", lo_min, 657);
        cmp("line.hsync_last", lo_max, 752);
`else
        cmp("line.hsync_first", lo_min, 656);
        cmp("line.hsync_last", lo_max, 751);
`endif
        cmp("line.period_clks", period, 1600);

        // Tiny raster: frame period 15*8 = 120 ticks = 120 clks.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1;
            if (s_fs) found = 1;
        end
        cmp("frame.first_fs_seen", int'(found), 1);
        fs_cnt = 0; fs_gap = -1; fs_last = n_e; vs_cnt = 0; de_bad = 0;
        for (int i = 0; i < 240; i++) begin
            @(posedge clk); #1;
            if (s_fs) begin
                fs_cnt++;
                fs_gap = n_e - fs_last;
                fs_last = n_e;
            end
            if (i < 120 && !s_vs) vs_cnt++;
            if (s_de && s_row >= 16'd4) de_bad++;
        end
        cmp("frame.fs_pulses", fs_cnt, 2);
        cmp("frame.fs_gap_clks", fs_gap, 120);
        cmp("frame.vsync_ticks", vs_cnt, 30);
        cmp("frame.de_in_vblank", de_bad, 0);

        // Reset in the middle of a frame.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #1;
            if (s_row == 16'd2 && s_col == 16'd5) found = 1;
        end
        cmp("midreset.pos_seen", int'(found), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        release_and_check_start("restart");
        repeat (40) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
